ctrl_pipe_regs: RTL

//   Consumer side of the ID-stage decoder. Carries the decoded control bundles
//   (id/alu/ex/mem/wr ctrl), destination register and load flag from ID through
//   the ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/ctrl_pipe_regs.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_regs.sv
// Purpose : carries decoded control bundles from ID through the ID/EX, EX/MEM and MEM/WB registers.
// Latency : 1 clk to EX, 2 clks to MEM, 3 clks to WB; stall/flush insert a bubble into EX.
// Backpressure: mem_busy freezes every stage; optional CTRL_PERF_CNT_EN adds stall/flush counters.
module ctrl_pipe_regs #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_busy,
    input  logic [3:0]       id_ctrl_in,
    input  logic [5:0]       alu_ctrl_in,
    input  logic [6:0]       ex_ctrl_in,
    input  logic [4:0]       mem_ctrl_in,
    input  logic [1:0]       wr_ctrl_in,
    input  logic [4:0]       id_rw,
    input  logic             id_is_load,
    output logic             ex_valid,
    output logic [5:0]       ex_alu_ctrl,
    output logic [6:0]       ex_ex_ctrl,
    output logic [4:0]       ex_rw,
    output logic             ex_is_load,
    output logic             mem_valid,
    output logic [4:0]       mem_mem_ctrl,
    output logic [4:0]       mem_rw,
    output logic             mem_is_load,
    output logic             wb_valid,
    output logic             wb_wsrc,
    output logic [4:0]       wb_rw,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Everything EX and later stages still need; idCtrl is consumed in ID.
    typedef struct packed {
        logic       valid;
        logic [5:0] aluCtrl;
        logic [6:0] exCtrl;
        logic [4:0] memCtrl;
        logic [1:0] wrCtrl;
        logic [4:0] rw;
        logic       isLoad;
    } exBundle_t;

    // ALU and EX controls are dropped once the instruction leaves EX.
    typedef struct packed {
        logic       valid;
        logic [4:0] memCtrl;
        logic [1:0] wrCtrl;
        logic [4:0] rw;
        logic       isLoad;
    } memBundle_t;

    // Only writeback information survives into WB.
    typedef struct packed {
        logic       valid;
        logic [1:0] wrCtrl;
        logic [4:0] rw;
    } wbBundle_t;

    exBundle_t  idBundle;
    exBundle_t  exReg;
    memBundle_t memReg;
    wbBundle_t  wbReg;
    logic       bubbleIn;
    logic       advance;

    // The link bit of idCtrl already travels in ex_ctrl_in[2], so the
    // bundle itself is not stored; the reduction only marks it as seen.
    logic unusedIdCtrl;
    assign unusedIdCtrl = ^id_ctrl_in;

    // A frozen memory holds the whole pipe; stall and flush lose to it.
    assign advance  = ~mem_busy;
    assign bubbleIn = stall | flush | ~id_valid;

    // Build the ID/EX next value: a real bundle or an all-zero bubble.
    always_comb begin
        idBundle = '0;
        if (!bubbleIn) begin
            idBundle.valid   = 1'b1;
            idBundle.aluCtrl = alu_ctrl_in;
            idBundle.exCtrl  = ex_ctrl_in;
            idBundle.memCtrl = mem_ctrl_in;
            idBundle.wrCtrl  = wr_ctrl_in;
            idBundle.rw      = id_rw;
            idBundle.isLoad  = id_is_load;
        end
    end

    // ID/EX register: loads the ID bundle or a bubble unless memory is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exReg <= '0;
        end else if (advance) begin
            exReg <= idBundle;
        end
    end

    // EX/MEM register: bubbles in EX are already zero, so a plain copy keeps them clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memReg <= '0;
        end else if (advance) begin
            memReg.valid   <= exReg.valid;
            memReg.memCtrl <= exReg.memCtrl;
            memReg.wrCtrl  <= exReg.wrCtrl;
            memReg.rw      <= exReg.rw;
            memReg.isLoad  <= exReg.isLoad;
        end
    end

    // MEM/WB register: carries the writeback select and destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbReg <= '0;
        end else if (advance) begin
            wbReg.valid  <= memReg.valid;
            wbReg.wrCtrl <= memReg.wrCtrl;
            wbReg.rw     <= memReg.rw;
        end
    end

    assign ex_valid     = exReg.valid;
    assign ex_alu_ctrl  = exReg.aluCtrl;
    assign ex_ex_ctrl   = exReg.exCtrl;
    assign ex_rw        = exReg.rw;
    assign ex_is_load   = exReg.isLoad;

    assign mem_valid    = memReg.valid;
    assign mem_mem_ctrl = memReg.memCtrl;
    assign mem_rw       = memReg.rw;
    assign mem_is_load  = memReg.isLoad;

    // r0 is hardwired, so a write aimed at it is never enabled.
    assign wb_valid     = wbReg.valid;
    assign wb_wsrc      = wbReg.wrCtrl[0];
    assign wb_rw        = wbReg.rw;
    assign wb_we        = wbReg.valid & wbReg.wrCtrl[1] & (wbReg.rw != 5'd0);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    // Saturating bubble counters; flush wins when both requests arrive together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (advance) begin
            if (flush) begin
                if (flushCnt != '1) begin
                    flushCnt <= flushCnt + CNT_W'(1);
                end
            end else if (stall) begin
                if (stallCnt != '1) begin
                    stallCnt <= stallCnt + CNT_W'(1);
                end
            end
        end
    end

    assign stall_cnt = stallCnt;
    assign flush_cnt = flushCnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
